// File: rtl/avalon_pio_out_hs.sv
// Avalon-MM output PIO with a valid/ack handshake toward the consumer, sticky overrun/done flags and a level irq.
// Optional: define PIO_SETCLR_EN to add OUTSET (offset 2) and OUTCLEAR (offset 3) data-register updates.
module avalon_pio_out_hs #(
    parameter int DATA_WIDTH  = 9,
    parameter int RESET_VALUE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  out_valid,
    input  logic                  out_ack,
    output logic                  irq
);

    localparam logic [DATA_WIDTH-1:0] RST_DATA = DATA_WIDTH'(RESET_VALUE);

    logic [DATA_WIDTH-1:0] data_reg;
    logic [DATA_WIDTH-1:0] next_data;
    logic                  pending;
    logic                  overrun;
    logic                  done;
    logic                  irq_en;

    logic wr_en;
    logic data_sel;
    logic data_wr;
    logic status_wr;
    logic handshake;
    logic load;
    logic drop;
    logic unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign status_wr = wr_en & (address == 3'd1);
    assign handshake = pending & out_ack;
    assign data_wr   = wr_en & data_sel;
    // A completing handshake frees the slot in the same cycle, so the write is taken.
    assign load      = data_wr & (~pending | out_ack);
    assign drop      = data_wr & pending & ~out_ack;
    assign unused_wd = ^writedata;

    always_comb begin
        next_data = writedata[DATA_WIDTH-1:0];
        data_sel  = (address == 3'd0);
`ifdef PIO_SETCLR_EN
        case (address)
            3'd2: begin
                data_sel  = 1'b1;
                next_data = data_reg | writedata[DATA_WIDTH-1:0];
            end
            3'd3: begin
                data_sel  = 1'b1;
                next_data = data_reg & ~writedata[DATA_WIDTH-1:0];
            end
            default: ;
        endcase
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg <= RST_DATA;
        end else if (load) begin
            data_reg <= next_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (load) begin
            pending <= 1'b1;
        end else if (handshake) begin
            pending <= 1'b0;
        end
    end

    // Flag set events take priority over software clears in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
            done    <= 1'b0;
            irq_en  <= 1'b0;
        end else begin
            if (drop) begin
                overrun <= 1'b1;
            end else if (status_wr && writedata[1]) begin
                overrun <= 1'b0;
            end
            if (handshake) begin
                done <= 1'b1;
            end else if (status_wr && writedata[2]) begin
                done <= 1'b0;
            end
            if (status_wr) begin
                irq_en <= writedata[3];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            3'd0: readdata[DATA_WIDTH-1:0] = data_reg;
            3'd1: readdata[3:0] = {irq_en, done, overrun, pending};
`ifdef PIO_SETCLR_EN
            3'd2: readdata[DATA_WIDTH-1:0] = data_reg;
            3'd3: readdata[DATA_WIDTH-1:0] = data_reg;
`endif
            default: ;
        endcase
    end

    assign out_port  = data_reg;
    assign out_valid = pending;
    assign irq       = done & irq_en;

endmodule

// File: tb/tb_avalon_pio_out_hs.sv
// Scoreboard bench for avalon_pio_out_hs: directed scenarios plus random traffic against a behavioural model.
module tb_avalon_pio_out_hs;

    localparam int DW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [DW-1:0] out_port;
    logic          out_valid;
    logic          out_ack;
    logic          irq;

    int n_checks = 0;
    int n_fail   = 0;

    avalon_pio_out_hs #(.DATA_WIDTH(DW), .RESET_VALUE(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .out_valid  (out_valid),
        .out_ack    (out_ack),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] port;
        logic          vld;
        logic          irq;
        logic [31:0]   rd;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model state
    logic [DW-1:0] m_data;
    logic          m_pend, m_ovr, m_done, m_ien;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        logic [31:0] r;
        r = 32'd0;
        if (a == 3'd0) r = 32'(m_data);
        else if (a == 3'd1) r = {28'd0, m_ien, m_done, m_ovr, m_pend};
`ifdef PIO_SETCLR_EN
        else if (a == 3'd2 || a == 3'd3) r = 32'(m_data);
`endif
        return r;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic          wr, hs, is_data;
        logic [DW-1:0] val;
        exp_t          e;
        if (reset) begin
            m_data = '0; m_pend = 0; m_ovr = 0; m_done = 0; m_ien = 0;
        end else begin
            wr      = chipselect && !write_n;
            hs      = m_pend && out_ack;
            is_data = wr && (address == 3'd0);
            val     = writedata[DW-1:0];
`ifdef PIO_SETCLR_EN
            if (wr && address == 3'd2) begin is_data = 1; val = m_data | writedata[DW-1:0]; end
            if (wr && address == 3'd3) begin is_data = 1; val = m_data & ~writedata[DW-1:0]; end
`endif
            if (wr && address == 3'd1) begin
                if (writedata[1]) m_ovr = 0;
                if (writedata[2]) m_done = 0;
                m_ien = writedata[3];
            end
            if (is_data && m_pend && !out_ack) m_ovr = 1;
            if (hs) begin
                m_done = 1;
                m_pend = 0;
            end
            if (is_data && (!m_pend || hs)) begin
                // m_pend already cleared by hs, so a plain empty slot check covers both cases
                m_data = val;
                m_pend = 1;
            end else if (is_data && !hs && !m_pend) begin
                m_data = val;
                m_pend = 1;
            end
        end
        e.port = m_data;
        e.vld  = m_pend;
        e.irq  = m_done && m_ien;
        e.rd   = model_read(address);
        exp_q.push_back(e);
    endtask

    task automatic drive_now(input logic cs, input logic wn, input logic [2:0] a,
                             input logic [31:0] wd, input logic ack);
        chipselect = cs; write_n = wn; address = a; writedata = wd; out_ack = ack;
        model_step();
    endtask

    task automatic cyc(input logic cs, input logic wn, input logic [2:0] a,
                       input logic [31:0] wd, input logic ack);
        @(negedge clk);
        drive_now(cs, wn, a, wd, ack);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int n);
        reset = 1;
        for (int i = 0; i < n; i++) cyc(0, 1, 3'd0, 0, 0);
        reset = 0;
    endtask

    // Monitor: compare each clocked result against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_out_port", 32'(out_port), 32'(e.port));
                chk("sb_out_valid", 32'(out_valid), 32'(e.vld));
                chk("sb_irq", 32'(irq), 32'(e.irq));
                chk("sb_readdata", readdata, e.rd);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; chipselect = 0; write_n = 1; address = 0; writedata = 0; out_ack = 0;
        m_data = '0; m_pend = 0; m_ovr = 0; m_done = 0; m_ien = 0;

        // Reset values
        do_reset(3);
        cyc(1, 1, 3'd0, 0, 0);
        settle(); chk("rst_data_read", readdata, 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        cyc(1, 1, 3'd1, 0, 0);
        settle(); chk("rst_status_read", readdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);

        // Load then overrun
        cyc(1, 0, 3'd0, 32'h1A5, 0);
        settle(); chk("load_port", 32'(out_port), 32'h1A5);
        chk("load_valid", 32'(out_valid), 32'h1);
        cyc(1, 0, 3'd0, 32'h0FF, 0);
        cyc(1, 1, 3'd1, 0, 0);
        settle(); chk("ovr_port", 32'(out_port), 32'h1A5);
        chk("ovr_status", readdata, 32'h3);

        // Write in the same cycle as a completing handshake
        cyc(1, 0, 3'd0, 32'h055, 1);
        cyc(1, 1, 3'd1, 0, 0);
        settle(); chk("hs_wr_port", 32'(out_port), 32'h055);
        chk("hs_wr_valid", 32'(out_valid), 32'h1);
        chk("hs_wr_status", readdata, 32'h7);

        // Interrupt enable and done clearing
        cyc(1, 0, 3'd1, 32'h8, 0);
        cyc(0, 1, 3'd0, 0, 1);
        settle(); chk("irq_set", 32'(irq), 32'h1);
        cyc(1, 0, 3'd1, 32'h4, 0);
        settle(); chk("irq_clr", 32'(irq), 32'h0);
        cyc(1, 0, 3'd0, 32'h011, 0);
        cyc(1, 0, 3'd1, 32'hC, 1);
        cyc(1, 1, 3'd1, 0, 0);
        settle(); chk("done_set_wins", 32'(readdata[2]), 32'h1);

        // Set/clear offsets
        do_reset(2);
        cyc(1, 0, 3'd0, 32'h100, 0);
        cyc(0, 1, 3'd0, 0, 1);
        cyc(1, 0, 3'd2, 32'h003, 0);
        cyc(1, 1, 3'd2, 0, 0);
`ifdef PIO_SETCLR_EN
        settle(); chk("outset_port", 32'(out_port), 32'h103);
        chk("outset_read", readdata, 32'h103);
        cyc(0, 1, 3'd0, 0, 1);
        cyc(1, 0, 3'd3, 32'h101, 0);
        cyc(1, 1, 3'd3, 0, 0);
        settle(); chk("outclr_port", 32'(out_port), 32'h002);
`else
        settle(); chk("outset_port", 32'(out_port), 32'h100);
        chk("outset_read", readdata, 32'h0);
`endif

        // Asynchronous reset while a value is pending
        cyc(1, 0, 3'd0, 32'h1FF, 1);
        cyc(1, 1, 3'd1, 0, 0);
        settle(); chk("pre_rst_valid", 32'(out_valid), 32'h1);
        @(negedge clk);
        reset = 1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_port", 32'(out_port), 32'h0);
        drive_now(1, 1, 3'd1, 0, 1);
        cyc(1, 1, 3'd1, 0, 1);
        reset = 0;
        cyc(1, 1, 3'd1, 0, 0);
        settle(); chk("post_rst_status", readdata, 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [2:0]  a;
            logic [31:0] wd;
            @(negedge clk);
            reset = ($urandom_range(0, 249) == 0);
            a = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
            wd = $urandom();
            drive_now(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 0), a, wd,
                      ($urandom_range(0, 2) == 0));
        end
        @(negedge clk);
        reset = 0;
        drive_now(0, 1, 3'd1, 0, 0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
